data_router_ctrl: RTL and testbench



---
 rtl/data_router_pkg.sv | 20 ++
 rtl/data_router_ctrl_if.sv | 15 +
 rtl/data_router_addr_gen.sv | 61 ++++++
 rtl/data_router_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_data_router_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_router_pkg.sv
// Shared types and widths for the data router command sequencer.
// Command select encodings, controller states and the column field width.
package data_router_pkg;
  localparam int COLW = 28;

  typedef enum logic [1:0] {
    RR = 2'b00,
    BR = 2'b01,
    RP = 2'b10,
    NE = 2'b11
  } rpsel_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SWEEP,
    S_WAIT_BLK,
    S_FIN
  } ctrl_state_e;
endpackage

// File: rtl/data_router_ctrl_if.sv
// Command bus from the sequencer to the data router / PE array.
// valid/ready handshake; a command is consumed on cmd_valid & cmd_ready.
interface data_router_ctrl_if;
  import data_router_pkg::*;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      bank;
  logic [1:0]      row;
  logic [COLW-1:0] col;
  rpsel_e          rpsel;

  modport master (output cmd_valid, bank, row, col, rpsel, input cmd_ready);
  modport slave  (input cmd_valid, bank, row, col, rpsel, output cmd_ready);
endinterface

// File: rtl/data_router_addr_gen.sv
// Row / column / tile counters for the sequencer, with step/clear controls and end-of-range flags.
// Column counter is one bit wider than the column field so c+STRIDE never wraps.
module data_router_addr_gen
  import data_router_pkg::*;
#(
  parameter int BUFH   = 3,
  parameter int KSIZE  = 3,
  parameter int STRIDE = 1,
  parameter int TILEW  = 16,
  localparam int RW    = (BUFH > 1) ? $clog2(BUFH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_clr,
  input  logic             c_step,
  input  logic             c_clr,
  input  logic             r_step,
  input  logic             r_clr,
  input  logic             t_step,
  input  logic [COLW-1:0]  cols,
  input  logic [TILEW-1:0] tiles,
  output logic [1:0]       row,
  output logic [COLW-1:0]  col,
  output logic             c_last,
  output logic             r_last,
  output logic             t_last
);
  logic [COLW:0]    c_q, c_d;
  logic [RW-1:0]    r_q, r_d;
  logic [TILEW-1:0] tile_q, tile_d;

  always_comb begin
    c_d    = c_q;
    r_d    = r_q;
    tile_d = tile_q;
    if (cnt_clr || c_clr)   c_d = '0;
    else if (c_step)        c_d = c_q + (COLW+1)'(STRIDE);
    if (cnt_clr || r_clr)   r_d = '0;
    else if (r_step)        r_d = r_q + RW'(1);
    if (cnt_clr)            tile_d = '0;
    else if (t_step)        tile_d = tile_q + TILEW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q    <= '0;
      r_q    <= '0;
      tile_q <= '0;
    end else begin
      c_q    <= c_d;
      r_q    <= r_d;
      tile_q <= tile_d;
    end
  end

  assign c_last = (c_q + (COLW+1)'(STRIDE)) >= {1'b0, cols};
  assign r_last = (r_q == RW'(KSIZE - 1));
  assign t_last = (tile_q == tiles - TILEW'(1));
  assign row    = 2'(r_q);
  assign col    = c_q[COLW-1:0];
endmodule

// File: rtl/data_router_ctrl.sv
// Data router command sequencer: per tile, KSIZE x (all-bank row load + strided pixel sweep), then wait for blkend.
// Optional DATA_ROUTER_CTRL_PERF_EN adds a saturating stall_cnt output (cycles with cmd_valid & !cmd_ready).
module data_router_ctrl
  import data_router_pkg::*;
#(
  parameter int POY    = 3,
  parameter int BUFH   = 3,
  parameter int BUFW   = 32,
  parameter int KSIZE  = 3,
  parameter int STRIDE = 1,
  parameter int TILEW  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [COLW-1:0]     cfg_cols,
  input  logic [TILEW-1:0]    cfg_tiles,
  input  logic                blkend,
  output logic                busy,
  output logic                done,
  data_router_ctrl_if.master  cmd
`ifdef DATA_ROUTER_CTRL_PERF_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);
  if (KSIZE > BUFH) begin : g_ksize_chk
    $error("KSIZE must not exceed BUFH");
  end
  if (STRIDE < 1) begin : g_stride_chk
    $error("STRIDE must be at least 1");
  end
  if (POY > 4) begin : g_poy_chk
    $error("bank field is 2 bits wide");
  end

  ctrl_state_e      state_q, state_d;
  logic [COLW-1:0]  cols_q, cols_d;
  logic [TILEW-1:0] tiles_q, tiles_d;
  logic             blk_seen_q, blk_seen_d;
  logic             cmd_valid_q, cmd_valid_d;
  rpsel_e           rpsel_q, rpsel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic accept, row_end;
  logic cnt_clr, c_step, c_clr, r_step, r_clr, t_step;
  logic c_last, r_last, t_last;
  logic [1:0]      row_w;
  logic [COLW-1:0] col_w;

  data_router_addr_gen #(
    .BUFH(BUFH), .KSIZE(KSIZE), .STRIDE(STRIDE), .TILEW(TILEW)
  ) u_addr_gen (
    .clk(clk), .rst(rst), .cnt_clr(cnt_clr),
    .c_step(c_step), .c_clr(c_clr), .r_step(r_step), .r_clr(r_clr), .t_step(t_step),
    .cols(cols_q), .tiles(tiles_q),
    .row(row_w), .col(col_w),
    .c_last(c_last), .r_last(r_last), .t_last(t_last)
  );

  always_comb begin
    state_d     = state_q;
    cols_d      = cols_q;
    tiles_d     = tiles_q;
    blk_seen_d  = blk_seen_q;
    cmd_valid_d = cmd_valid_q;
    rpsel_d     = rpsel_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_clr     = 1'b0;
    c_step      = 1'b0;
    c_clr       = 1'b0;
    r_step      = 1'b0;
    r_clr       = 1'b0;
    t_step      = 1'b0;
    row_end     = 1'b0;
    accept      = cmd_valid_q & cmd.cmd_ready;

    // An early blkend is remembered so WAIT_BLK can leave immediately.
    if (blkend && state_q != S_IDLE && state_q != S_WAIT_BLK) blk_seen_d = 1'b1;

    unique case (state_q)
      S_IDLE: if (start) begin
        cols_d  = (cfg_cols > COLW'(BUFW)) ? COLW'(BUFW) : cfg_cols;
        tiles_d = cfg_tiles;
        busy_d  = 1'b1;
        cnt_clr = 1'b1;
        if (cfg_tiles == '0) begin
          state_d = S_FIN;
        end else begin
          state_d     = S_LOAD;
          cmd_valid_d = 1'b1;
          rpsel_d     = RR;
        end
      end
      S_LOAD: if (accept) begin
        if (cols_q == '0) begin
          row_end = 1'b1;
        end else begin
          state_d = S_SWEEP;
          rpsel_d = RP;
        end
      end
      S_SWEEP: if (accept) begin
        if (c_last) row_end = 1'b1;
        else        c_step  = 1'b1;
      end
      S_WAIT_BLK: if (blkend || blk_seen_q) begin
        blk_seen_d = 1'b0;
        t_step     = 1'b1;
        r_clr      = 1'b1;
        if (t_last) begin
          state_d = S_FIN;
        end else begin
          state_d     = S_LOAD;
          cmd_valid_d = 1'b1;
          rpsel_d     = RR;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (row_end) begin
      c_clr   = 1'b1;
      rpsel_d = RR;
      if (r_last) begin
        state_d     = S_WAIT_BLK;
        cmd_valid_d = 1'b0;
      end else begin
        r_step  = 1'b1;
        state_d = S_LOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cols_q      <= '0;
      tiles_q     <= '0;
      blk_seen_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      rpsel_q     <= RR;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cols_q      <= cols_d;
      tiles_q     <= tiles_d;
      blk_seen_q  <= blk_seen_d;
      cmd_valid_q <= cmd_valid_d;
      rpsel_q     <= rpsel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmd.cmd_valid = cmd_valid_q;
  assign cmd.rpsel     = rpsel_q;
  assign cmd.bank      = 2'b00;
  assign cmd.row       = row_w;
  assign cmd.col       = col_w;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef DATA_ROUTER_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_IDLE && start)
      stall_cnt_d = '0;
    else if (cmd_valid_q && !cmd.cmd_ready && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_data_router_ctrl.sv
// Bench for data_router_ctrl: STRIDE=1 instance u_dut (ready driven by the bench) and STRIDE=2 instance u_dut2 (ready tied high).
module tb_data_router_ctrl;
  import data_router_pkg::*;

  typedef struct packed {
    logic [1:0]      rpsel;
    logic [1:0]      row;
    logic [COLW-1:0] col;
  } cmd_t;

  typedef struct {
    int cols;
    int tiles;
    int n1;
    int n2;
    int maxc1;
    int maxc2;
    int rr;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst, start, blkend;
  logic [COLW-1:0] cfg_cols;
  logic [15:0]     cfg_tiles;
  logic            busy1, done1, busy2, done2;
`ifdef DATA_ROUTER_CTRL_PERF_EN
  logic [31:0]     stall1, stall2;
`endif

  data_router_ctrl_if if1();
  data_router_ctrl_if if2();
  assign if2.cmd_ready = 1'b1;

  always #5 clk = ~clk;

  data_router_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .cfg_cols(cfg_cols), .cfg_tiles(cfg_tiles),
    .blkend(blkend), .busy(busy1), .done(done1), .cmd(if1)
`ifdef DATA_ROUTER_CTRL_PERF_EN
    , .stall_cnt(stall1)
`endif
  );

  data_router_ctrl #(.STRIDE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .cfg_cols(cfg_cols), .cfg_tiles(cfg_tiles),
    .blkend(blkend), .busy(busy2), .done(done2), .cmd(if2)
`ifdef DATA_ROUTER_CTRL_PERF_EN
    , .stall_cnt(stall2)
`endif
  );

  // Monitor: records accepted commands and done pulses; cleared while rst is high.
  cmd_t q1[$];
  int   n2, rr1, maxc1, maxc2, done_n1, done_n2;

  always @(negedge clk) begin
    if (rst) begin
      q1.delete();
      n2 = 0; rr1 = 0; maxc1 = -1; maxc2 = -1; done_n1 = 0; done_n2 = 0;
    end else begin
      if (if1.cmd_valid && if1.cmd_ready) begin
        q1.push_back({if1.rpsel, if1.row, if1.col});
        if (if1.rpsel == RR) rr1++;
        if (int'(if1.col) > maxc1) maxc1 = int'(if1.col);
      end
      if (if2.cmd_valid && if2.cmd_ready) begin
        n2++;
        if (int'(if2.col) > maxc2) maxc2 = int'(if2.col);
      end
      if (done1) done_n1++;
      if (done2) done_n2++;
    end
  end

  int   checks = 0;
  int   errors = 0;
  bit   ok;
  cmd_t exp_seq[15];
  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [1:0] rp, input int r, input int c);
    return {rp, 2'(r), COLW'(c)};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; blkend = 1'b0; if1.cmd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start(input int cols, input int tiles);
    @(posedge clk); #1;
    cfg_cols = COLW'(cols); cfg_tiles = 16'(tiles); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_blkend();
    blkend = 1'b1;
    @(posedge clk); #1;
    blkend = 1'b0;
  endtask

  task automatic wait_for(input int kind, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(negedge clk); #1;
      case (kind)
        0: hit = !if1.cmd_valid && busy1;
        1: hit = !if1.cmd_valid && busy1 && !if2.cmd_valid && busy2;
        2: hit = done_n1 > 0 && done_n2 > 0;
        3: hit = done_n1 > 0;
        4: hit = if1.cmd_valid && if1.rpsel == RP;
        default: hit = if1.cmd_valid && if1.rpsel == RP && if1.row == 2'd0 && if1.col == COLW'(1);
      endcase
    end
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_len"}, q1.size(), 15);
    for (int i = 0; i < 15; i++)
      if (i < q1.size()) chk($sformatf("%s_cmd%0d", tag, i), int'(q1[i]), int'(exp_seq[i]));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; blkend = 1'b0; cfg_cols = '0; cfg_tiles = '0;
    if1.cmd_ready = 1'b1;

    exp_seq = '{mk(2'b00,0,0), mk(2'b10,0,0), mk(2'b10,0,1), mk(2'b10,0,2), mk(2'b10,0,3),
                mk(2'b00,1,0), mk(2'b10,1,0), mk(2'b10,1,1), mk(2'b10,1,2), mk(2'b10,1,3),
                mk(2'b00,2,0), mk(2'b10,2,0), mk(2'b10,2,1), mk(2'b10,2,2), mk(2'b10,2,3)};
    //            cols tiles n1  n2  maxc1 maxc2 rr
    vecs = '{'{   4,   1,   15,  9,   3,    2,   3},
             '{   5,   1,   18, 12,   4,    4,   3},
             '{  40,   1,   99, 51,  31,   30,   3},
             '{   0,   2,    6,  6,   0,    0,   6},
             '{   1,   2,   12, 12,   0,    0,   6},
             '{   3,   3,   36, 27,   2,    2,   9}};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_valid", int'(if1.cmd_valid), 0);
    chk("rst_busy_done", int'({busy1, done1}), 0);
    chk("rst_fields", int'({if1.bank, if1.rpsel, if1.row, if1.col}), 0);

    // Basic tile: RR + RP c0..3 for each of three rows, then blkend -> done
    pulse_start(4, 1);
    @(negedge clk);
    chk("first_cmd", int'({busy1, if1.cmd_valid, if1.rpsel, if1.row}), int'({1'b1, 1'b1, 2'b00, 2'd0}));
    wait_for(0, ok); chk("t1_wait_blk", int'(ok), 1);
    check_seq("t1");
    pulse_blkend();
    @(negedge clk);
    chk("t1_fin_cycle", int'({busy1, done1}), int'(2'b10));
    @(negedge clk);
    chk("t1_done_cycle", int'({busy1, done1}), int'(2'b01));
    @(negedge clk);
    chk("t1_done_width", int'(done1), 0);

    // Five stall cycles while RP row0 col2 is on the bus
    do_reset();
    pulse_start(4, 1);
    wait_for(5, ok); chk("t2_reach_col1", int'(ok), 1);
    @(posedge clk); #1 if1.cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t2_hold%0d", i), int'({if1.cmd_valid, if1.rpsel, if1.row, if1.col}),
          int'({1'b1, 2'b10, 2'd0, COLW'(2)}));
      @(posedge clk); #1;
    end
    if1.cmd_ready = 1'b1;
    wait_for(0, ok); chk("t2_wait_blk", int'(ok), 1);
    check_seq("t2");
`ifdef DATA_ROUTER_CTRL_PERF_EN
    chk("t2_stall_cnt", int'(stall1), 5);
`endif

    // Early blkend during tile0 sweep; WAIT_BLK lasts one cycle, tile1 waits for a real blkend
    do_reset();
    pulse_start(4, 2);
    wait_for(4, ok); chk("t4_reach_sweep", int'(ok), 1);
    pulse_blkend();
    wait_for(0, ok); chk("t4_wait0", int'(ok), 1);
    @(negedge clk);
    chk("t4_wait_exit", int'({if1.cmd_valid, if1.rpsel, if1.row}), int'({1'b1, 2'b00, 2'd0}));
    wait_for(0, ok); chk("t4_wait1", int'(ok), 1);
    repeat (3) @(negedge clk);
    chk("t4_still_waiting", int'({busy1, if1.cmd_valid, done1}), int'(3'b100));
    pulse_blkend();
    wait_for(3, ok); chk("t4_done", int'(ok), 1);
    chk("t4_cmds", q1.size(), 30);
    chk("t4_done_cnt", done_n1, 1);

    // Zero tiles: no commands, done two cycles after start
    do_reset();
    pulse_start(4, 0);
    @(negedge clk);
    chk("t5_c1", int'({busy1, done1, if1.cmd_valid}), int'(3'b100));
    @(negedge clk);
    chk("t5_c2", int'({busy1, done1, if1.cmd_valid}), int'(3'b010));
    repeat (3) @(negedge clk);
    chk("t5_no_cmds", q1.size() + n2, 0);
    chk("t5_done_cnt", done_n1, 1);

    // Reset mid tile1 sweep, then a clean rerun
    do_reset();
    pulse_start(4, 2);
    wait_for(0, ok); chk("t6_wait0", int'(ok), 1);
    pulse_blkend();
    wait_for(4, ok); chk("t6_tile1_sweep", int'(ok), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_after_rst", int'({if1.cmd_valid, busy1, done1, if1.rpsel, if1.row, if1.col}), 0);
`ifdef DATA_ROUTER_CTRL_PERF_EN
    chk("t6_stall_rst", int'(stall1), 0);
`endif
    repeat (4) @(negedge clk);
    chk("t6_no_done", done_n1, 0);
    pulse_start(4, 1);
    wait_for(0, ok); chk("t6_wait_rerun", int'(ok), 1);
    check_seq("t6");
    pulse_blkend();
    wait_for(3, ok); chk("t6_done", int'(ok), 1);

    // Table: both instances, compared on counts and column extremes
    for (int v = 0; v < 6; v++) begin
      do_reset();
      pulse_start(vecs[v].cols, vecs[v].tiles);
      for (int t = 0; t < vecs[v].tiles; t++) begin
        wait_for(1, ok); chk($sformatf("v%0d_wait_t%0d", v, t), int'(ok), 1);
        pulse_blkend();
      end
      wait_for(2, ok); chk($sformatf("v%0d_done", v), int'(ok), 1);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_n1", v), q1.size(), vecs[v].n1);
      chk($sformatf("v%0d_n2", v), n2, vecs[v].n2);
      chk($sformatf("v%0d_maxc1", v), maxc1, vecs[v].maxc1);
      chk($sformatf("v%0d_maxc2", v), maxc2, vecs[v].maxc2);
      chk($sformatf("v%0d_rr", v), rr1, vecs[v].rr);
      chk($sformatf("v%0d_done_cnt", v), done_n1 * 10 + done_n2, 11);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
